// File: rtl/morse_pkg.sv
// Shared types for the Morse encoder: FSM states and the per-character code record.
// Codes are left-aligned and MSB-first; a pat bit of 1 is a dash.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYM,
    EGAP,
    CHAR,
    CGAP,
    WORD,
    WGAP
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       is_space;
    logic [2:0] len;
    logic [4:0] pat;
  } morse_code_t;

  localparam morse_code_t SPACE_CODE = '{valid: 1'b1, is_space: 1'b1, len: 3'd0, pat: 5'd0};

  function automatic morse_code_t mk_code(input logic [2:0] len, input logic [4:0] pat);
    morse_code_t c;
    c.valid    = 1'b1;
    c.is_space = 1'b0;
    c.len      = len;
    c.pat      = pat;
    return c;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/morse_code_rom.sv
// Combinational ASCII -> Morse code lookup; lower case folds onto upper case.
// Unsupported bytes return an all-zero record (valid = 0).
module morse_code_rom
  import morse_pkg::*;
(
  input  logic [7:0]  ascii_i,
  output morse_code_t code_o
);

  logic [7:0] up;

  always_comb begin
    up = ascii_i;
    if (ascii_i >= 8'h61 && ascii_i <= 8'h7A) up = ascii_i - 8'h20;
    code_o = '0;
    case (up)
      8'h20: code_o = SPACE_CODE;
      8'h41: code_o = mk_code(3'd2, 5'b01000);  // A .-
      8'h42: code_o = mk_code(3'd4, 5'b10000);  // B -...
      8'h43: code_o = mk_code(3'd4, 5'b10100);  // C -.-.
      8'h44: code_o = mk_code(3'd3, 5'b10000);  // D -..
      8'h45: code_o = mk_code(3'd1, 5'b00000);  // E .
      8'h46: code_o = mk_code(3'd4, 5'b00100);  // F ..-.
      8'h47: code_o = mk_code(3'd3, 5'b11000);  // G --.
      8'h48: code_o = mk_code(3'd4, 5'b00000);  // H ....
      8'h49: code_o = mk_code(3'd2, 5'b00000);  // I ..
      8'h4A: code_o = mk_code(3'd4, 5'b01110);  // J .---
      8'h4B: code_o = mk_code(3'd3, 5'b10100);  // K -.-
      8'h4C: code_o = mk_code(3'd4, 5'b01000);  // L .-..
      8'h4D: code_o = mk_code(3'd2, 5'b11000);  // M --
      8'h4E: code_o = mk_code(3'd2, 5'b10000);  // N -.
      8'h4F: code_o = mk_code(3'd3, 5'b11100);  // O ---
      8'h50: code_o = mk_code(3'd4, 5'b01100);  // P .--.
      8'h51: code_o = mk_code(3'd4, 5'b11010);  // Q --.-
      8'h52: code_o = mk_code(3'd3, 5'b01000);  // R .-.
      8'h53: code_o = mk_code(3'd3, 5'b00000);  // S ...
      8'h54: code_o = mk_code(3'd1, 5'b10000);  // T -
      8'h55: code_o = mk_code(3'd3, 5'b00100);  // U ..-
      8'h56: code_o = mk_code(3'd4, 5'b00010);  // V ...-
      8'h57: code_o = mk_code(3'd3, 5'b01100);  // W .--
      8'h58: code_o = mk_code(3'd4, 5'b10010);  // X -..-
      8'h59: code_o = mk_code(3'd4, 5'b10110);  // Y -.--
      8'h5A: code_o = mk_code(3'd4, 5'b11000);  // Z --..
      8'h30: code_o = mk_code(3'd5, 5'b11111);
      8'h31: code_o = mk_code(3'd5, 5'b01111);
      8'h32: code_o = mk_code(3'd5, 5'b00111);
      8'h33: code_o = mk_code(3'd5, 5'b00011);
      8'h34: code_o = mk_code(3'd5, 5'b00001);
      8'h35: code_o = mk_code(3'd5, 5'b00000);
      8'h36: code_o = mk_code(3'd5, 5'b10000);
      8'h37: code_o = mk_code(3'd5, 5'b11000);
      8'h38: code_o = mk_code(3'd5, 5'b11100);
      8'h39: code_o = mk_code(3'd5, 5'b11110);
      default: code_o = '0;
    endcase
  end

endmodule

// File: rtl/morse_encoder.sv
// ASCII byte -> one-cycle Morse symbol pulses; first symbol appears the cycle after acceptance.
// Single-byte handshake: ascii_ready is high only while idle, nothing is buffered while busy.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int ELEMENT_GAP = 1,
  parameter int CHAR_GAP    = 3,
  parameter int WORD_GAP    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic       dot_out,
  output logic       dash_out,
  output logic       char_space_out,
  output logic       word_space_out,
  output logic       bad_char,
  output logic       busy
);

  localparam int GAP_MAX = max3(ELEMENT_GAP, CHAR_GAP, WORD_GAP);
  localparam int GW      = $clog2(GAP_MAX + 1);

  localparam logic [GW-1:0] EGAP_LD = GW'(ELEMENT_GAP);
  localparam logic [GW-1:0] CGAP_LD = GW'(CHAR_GAP);
  localparam logic [GW-1:0] WGAP_LD = GW'(WORD_GAP);
  localparam logic [GW-1:0] GAP_ONE = GW'(1);

  state_t        state_q, state_d;
  logic [4:0]    pat_q, pat_d;
  logic [2:0]    elem_q, elem_d;
  logic [GW-1:0] gap_q, gap_d;

  logic ready_q, ready_d;
  logic dot_q, dot_d;
  logic dash_q, dash_d;
  logic cs_q, cs_d;
  logic ws_q, ws_d;
  logic bad_q, bad_d;
  logic busy_q, busy_d;

  morse_code_t code;
  logic        accept;

  morse_code_rom u_rom (
    .ascii_i (ascii_in),
    .code_o  (code)
  );

  assign accept = ascii_valid && ready_q;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    elem_d  = elem_q;
    gap_d   = gap_q;
    bad_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!code.valid) begin
            bad_d = 1'b1;
          end else if (code.is_space) begin
            state_d = WORD;
          end else begin
            state_d = SYM;
            pat_d   = code.pat;
            elem_d  = code.len;
          end
        end
      end
      SYM: begin
        state_d = EGAP;
        gap_d   = EGAP_LD;
        pat_d   = {pat_q[3:0], 1'b0};
        elem_d  = elem_q - 3'd1;
      end
      EGAP: begin
        if (gap_q <= GAP_ONE) state_d = (elem_q != 3'd0) ? SYM : CHAR;
        else gap_d = gap_q - GAP_ONE;
      end
      CHAR: begin
        state_d = CGAP;
        gap_d   = CGAP_LD;
      end
      CGAP: begin
        if (gap_q <= GAP_ONE) state_d = IDLE;
        else gap_d = gap_q - GAP_ONE;
      end
      WORD: begin
        state_d = WGAP;
        gap_d   = WGAP_LD;
      end
      WGAP: begin
        if (gap_q <= GAP_ONE) state_d = IDLE;
        else gap_d = gap_q - GAP_ONE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so each pulse lines up with its state.
    dot_d   = (state_d == SYM) && !pat_d[4];
    dash_d  = (state_d == SYM) && pat_d[4];
    cs_d    = (state_d == CHAR);
    ws_d    = (state_d == WORD);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE) && !accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      elem_q  <= '0;
      gap_q   <= '0;
      ready_q <= 1'b0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      cs_q    <= 1'b0;
      ws_q    <= 1'b0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      elem_q  <= elem_d;
      gap_q   <= gap_d;
      ready_q <= ready_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      cs_q    <= cs_d;
      ws_q    <= ws_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
    end
  end

  assign ascii_ready    = ready_q;
  assign dot_out        = dot_q;
  assign dash_out       = dash_q;
  assign char_space_out = cs_q;
  assign word_space_out = ws_q;
  assign bad_char       = bad_q;
  assign busy           = busy_q;

endmodule
